// File: rtl/i2s_tx_dsp_frame_sched.sv
// i2s_tx_dsp_frame_sched
//   Master-mode frame scheduler for the I2S TX DSP channel (sck domain).
//   - Generates a one-cycle DSP frame-sync (ws_o) at the start of every frame
//     and exposes the current bit/word slot position.
//   - Muxes two uDMA sample streams (src0/src1) onto the channel FIFO port in
//     strict ch0/ch1 order (or src0 only when 2-channel mode is off).
//   - Flags underruns (channel ready with no sample available while running).
// Ports:
//   sck_i, rst_i                 clock, async active-high reset
//   cfg_en_i/cfg_2ch_i           enable, 2-channel alternate mode
//   cfg_num_bits_i/num_word_i    bits per word - 1, words per frame - 1
//   src{0,1}_data/valid/ready    uDMA source streams
//   fifo_data/valid_o, ready_i   TX DSP channel FIFO interface
//   master_ready_to_send_i       channel primed; starts frame timing
//   ws_o, word_idx_o, bit_idx_o  frame sync and slot position
//   frame_cnt_o                  frames started since enable (wraps)
//   err_o, err_cnt_o             underrun pulse and saturating count
module i2s_tx_dsp_frame_sched #(
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   sck_i,
  input  logic                   rst_i,
  input  logic                   cfg_en_i,
  input  logic                   cfg_2ch_i,
  input  logic [4:0]             cfg_num_bits_i,
  input  logic [3:0]             cfg_num_word_i,
  input  logic [31:0]            src0_data_i,
  input  logic                   src0_valid_i,
  output logic                   src0_ready_o,
  input  logic [31:0]            src1_data_i,
  input  logic                   src1_valid_i,
  output logic                   src1_ready_o,
  output logic [31:0]            fifo_data_o,
  output logic                   fifo_valid_o,
  input  logic                   fifo_ready_i,
  input  logic                   master_ready_to_send_i,
  output logic                   ws_o,
  output logic [3:0]             word_idx_o,
  output logic [4:0]             bit_idx_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   err_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   ws_q, ws_d;
  logic [4:0]             bit_q, bit_d;
  logic [3:0]             word_q, word_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [4:0]             nb_q, nb_d;
  logic [3:0]             nw_q, nw_d;
  logic                   two_ch_q, two_ch_d;
  logic                   active;
  logic                   xfer;
  logic                   two_ch_eff;

  // State register
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; disable wins from any state
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: if (master_ready_to_send_i) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: combinational arbiter data path and underrun flag
  always_comb begin
    active       = (state_q != ST_IDLE);
    fifo_data_o  = sel_q ? src1_data_i : src0_data_i;
    fifo_valid_o = active & (sel_q ? src1_valid_i : src0_valid_i);
    src0_ready_o = active & ~sel_q & fifo_ready_i;
    src1_ready_o = active &  sel_q & fifo_ready_i;
    xfer         = fifo_valid_o & fifo_ready_i;
    err_o        = (state_q == ST_RUN) & fifo_ready_i & ~fifo_valid_o;
  end

  assign ws_o        = ws_q;
  assign bit_idx_o   = bit_q;
  assign word_idx_o  = word_q;
  assign frame_cnt_o = frame_q;
  assign err_cnt_o   = err_cnt_q;

  // Live 2ch setting until frame timing starts, latched copy afterwards
  assign two_ch_eff = (state_q == ST_RUN) ? two_ch_q : cfg_2ch_i;

  always_comb begin
    sel_d     = sel_q;
    ws_d      = 1'b0;
    bit_d     = bit_q;
    word_d    = word_q;
    frame_d   = frame_q;
    err_cnt_d = err_cnt_q;
    nb_d      = nb_q;
    nw_d      = nw_q;
    two_ch_d  = two_ch_q;
    if (state_d == ST_IDLE) begin
      sel_d     = 1'b0;
      bit_d     = '0;
      word_d    = '0;
      frame_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (xfer) sel_d = two_ch_eff ? ~sel_q : 1'b0;
      if (err_o && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      if (state_q == ST_ARMED && state_d == ST_RUN) begin
        // First RUN cycle is slot 0/0 and carries the first frame sync
        nb_d     = cfg_num_bits_i;
        nw_d     = cfg_num_word_i;
        two_ch_d = cfg_2ch_i;
        bit_d    = '0;
        word_d   = '0;
        ws_d     = 1'b1;
        frame_d  = frame_q + FRAME_CNT_W'(1);
      end else if (state_q == ST_RUN) begin
        if (bit_q == nb_q) begin
          bit_d  = '0;
          word_d = (word_q == nw_q) ? 4'd0 : word_q + 4'd1;
        end else begin
          bit_d  = bit_q + 5'd1;
        end
        // ws is registered, so it is derived from the next slot position
        ws_d = (bit_d == 5'd0) && (word_d == 4'd0);
        if (ws_d) frame_d = frame_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q     <= 1'b0;
      ws_q      <= 1'b0;
      bit_q     <= '0;
      word_q    <= '0;
      frame_q   <= '0;
      err_cnt_q <= '0;
      nb_q      <= '0;
      nw_q      <= '0;
      two_ch_q  <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      ws_q      <= ws_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      frame_q   <= frame_d;
      err_cnt_q <= err_cnt_d;
      nb_q      <= nb_d;
      nw_q      <= nw_d;
      two_ch_q  <= two_ch_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_dsp_frame_sched.sv
module tb_i2s_tx_dsp_frame_sched;

  localparam int ERR_W   = 8;
  localparam int FRAME_W = 16;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic               sck = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_en = 1'b0, cfg_2ch = 1'b0;
  logic [4:0]         cfg_num_bits = '0;
  logic [3:0]         cfg_num_word = '0;
  logic [31:0]        src0_data = '0, src1_data = '0;
  logic               src0_valid = 1'b0, src1_valid = 1'b0;
  logic               src0_ready, src1_ready;
  logic [31:0]        fifo_data;
  logic               fifo_valid;
  logic               fifo_ready = 1'b0;
  logic               master_ready = 1'b0;
  logic               ws;
  logic [3:0]         word_idx;
  logic [4:0]         bit_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               err;
  logic [ERR_W-1:0]   err_cnt;

  int checks = 0;
  int failures = 0;

  i2s_tx_dsp_frame_sched #(.ERR_CNT_W(ERR_W), .FRAME_CNT_W(FRAME_W)) dut (
    .sck_i(sck), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_2ch_i(cfg_2ch),
    .cfg_num_bits_i(cfg_num_bits), .cfg_num_word_i(cfg_num_word),
    .src0_data_i(src0_data), .src0_valid_i(src0_valid), .src0_ready_o(src0_ready),
    .src1_data_i(src1_data), .src1_valid_i(src1_valid), .src1_ready_o(src1_ready),
    .fifo_data_o(fifo_data), .fifo_valid_o(fifo_valid), .fifo_ready_i(fifo_ready),
    .master_ready_to_send_i(master_ready), .ws_o(ws), .word_idx_o(word_idx),
    .bit_idx_o(bit_idx), .frame_cnt_o(frame_cnt), .err_o(err), .err_cnt_o(err_cnt)
  );

  always #5 sck = ~sck;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at a falling edge with reset released and everything idle
  task automatic do_reset();
    rst = 1'b1; cfg_en = 1'b0; cfg_2ch = 1'b0; master_ready = 1'b0;
    fifo_ready = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
    repeat (2) @(posedge sck);
    @(negedge sck);
    rst = 1'b0;
  endtask

  // Called at a falling edge; returns #1 after the edge that starts RUN
  task automatic enter_run(input logic [4:0] nb, input logic [3:0] nw, input logic two);
    cfg_num_bits = nb; cfg_num_word = nw; cfg_2ch = two;
    cfg_en = 1'b1; master_ready = 1'b0;
    @(posedge sck);
    @(negedge sck);
    master_ready = 1'b1;
    @(posedge sck); #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #1;
    checks++; if (ws !== 1'b0) begin failures++; $display("FAIL reset_ws got=%b exp=0", ws); end
    rst = 1'b0;
    fifo_ready = 1'b1; src0_valid = 1'b1; src1_valid = 1'b1; #1;
    checks++; if (bit_idx !== 5'd0) begin failures++; $display("FAIL reset_bit got=%0d exp=0", bit_idx); end
    checks++; if (word_idx !== 4'd0) begin failures++; $display("FAIL reset_word got=%0d exp=0", word_idx); end
    checks++; if (frame_cnt !== '0) begin failures++; $display("FAIL reset_frame got=%0d exp=0", frame_cnt); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (fifo_valid !== 1'b0) begin failures++; $display("FAIL idle_fifo_valid got=%b exp=0", fifo_valid); end
    checks++; if ({src0_ready, src1_ready} !== 2'b00) begin failures++; $display("FAIL idle_readies got=%b exp=00", {src0_ready, src1_ready}); end
  endtask

  task automatic test_2ch_order();
    logic [31:0] q0[$], q1[$], exp[$];
    int ntx = 0;
    int msel;
    do_reset();
    for (int i = 0; i < 3; i++) begin q0.push_back($urandom); q1.push_back($urandom); end
    for (int i = 0; i < 3; i++) begin exp.push_back(q0[i]); exp.push_back(q1[i]); end
    cfg_en = 1'b1; cfg_2ch = 1'b1; fifo_ready = 1'b1;
    @(posedge sck);
    for (int cyc = 0; cyc < 60 && exp.size() > 0; cyc++) begin
      @(negedge sck);
      src0_valid = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      src1_valid = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      src0_data  = (q0.size() > 0) ? q0[0] : $urandom;
      src1_data  = (q1.size() > 0) ? q1[0] : $urandom;
      #1;
      msel = ntx % 2;
      checks++; if (src0_ready !== (msel == 0)) begin failures++; $display("FAIL order_src0_ready got=%b exp=%b", src0_ready, msel == 0); end
      checks++; if (src1_ready !== (msel == 1)) begin failures++; $display("FAIL order_src1_ready got=%b exp=%b", src1_ready, msel == 1); end
      checks++; if (fifo_valid !== (msel == 1 ? src1_valid : src0_valid)) begin failures++; $display("FAIL order_fifo_valid got=%b exp=%b", fifo_valid, msel == 1 ? src1_valid : src0_valid); end
      if (msel == 1 ? src1_valid : src0_valid) begin
        checks++; if (fifo_data !== exp[0]) begin failures++; $display("FAIL order_data got=%h exp=%h", fifo_data, exp[0]); end
        @(posedge sck);
        if (msel == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        void'(exp.pop_front());
        ntx++;
      end else begin
        @(posedge sck);
      end
    end
    checks++; if (exp.size() != 0) begin failures++; $display("FAIL order_drain remaining=%0d exp=0", exp.size()); end
  endtask

  task automatic test_frame_timing(input int nb, input int nw);
    int fl, n;
    int e_bit, e_word, e_frame;
    logic e_ws;
    do_reset();
    enter_run(5'(nb), 4'(nw), 1'b0);
    fl = (nb + 1) * (nw + 1);
    n  = 3 * fl + 2;
    for (int t = 0; t < n; t++) begin
      e_bit   = t % (nb + 1);
      e_word  = (t / (nb + 1)) % (nw + 1);
      e_ws    = (t % fl) == 0;
      e_frame = (t / fl + 1) % (1 << FRAME_W);
      checks++; if (ws !== e_ws) begin failures++; $display("FAIL ws nb=%0d nw=%0d t=%0d got=%b exp=%b", nb, nw, t, ws, e_ws); end
      checks++; if (bit_idx !== 5'(e_bit)) begin failures++; $display("FAIL bit_idx t=%0d got=%0d exp=%0d", t, bit_idx, e_bit); end
      checks++; if (word_idx !== 4'(e_word)) begin failures++; $display("FAIL word_idx t=%0d got=%0d exp=%0d", t, word_idx, e_word); end
      checks++; if (frame_cnt !== FRAME_W'(e_frame)) begin failures++; $display("FAIL frame_cnt t=%0d got=%0d exp=%0d", t, frame_cnt, e_frame); end
      @(negedge sck);
      // Config changes during RUN must not disturb the latched timing
      cfg_num_bits = 5'($urandom); cfg_num_word = 4'($urandom); cfg_2ch = 1'($urandom);
      @(posedge sck); #1;
    end
  endtask

  task automatic test_underrun();
    int e_sel = 0, e_cnt = 3;
    logic e_valid, e_err;
    do_reset();
    enter_run(5'd31, 4'd15, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sck);
      src0_valid = 1'b0; src1_valid = 1'b1; fifo_ready = 1'b1; #1;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL underrun_err i=%0d got=%b exp=1", i, err); end
      checks++; if ({src0_ready, src1_ready} !== 2'b10) begin failures++; $display("FAIL underrun_sel i=%0d got=%b exp=10", i, {src0_ready, src1_ready}); end
      @(posedge sck); #1;
    end
    checks++; if (err_cnt !== ERR_W'(3)) begin failures++; $display("FAIL underrun_cnt got=%0d exp=3", err_cnt); end
    for (int i = 0; i < 80; i++) begin
      @(negedge sck);
      src0_valid = 1'($urandom); src1_valid = 1'($urandom); fifo_ready = 1'($urandom);
      src0_data = $urandom; src1_data = $urandom; #1;
      e_valid = (e_sel == 1) ? src1_valid : src0_valid;
      e_err   = fifo_ready && !e_valid;
      checks++; if (fifo_valid !== e_valid) begin failures++; $display("FAIL rnd_fifo_valid i=%0d got=%b exp=%b", i, fifo_valid, e_valid); end
      checks++; if (err !== e_err) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, err, e_err); end
      checks++; if (src1_ready !== (fifo_ready && e_sel == 1)) begin failures++; $display("FAIL rnd_src1_ready i=%0d got=%b", i, src1_ready); end
      if (e_valid) begin
        checks++; if (fifo_data !== (e_sel == 1 ? src1_data : src0_data)) begin failures++; $display("FAIL rnd_data i=%0d got=%h", i, fifo_data); end
      end
      @(posedge sck); #1;
      if (fifo_ready && e_valid) e_sel = 1 - e_sel;
      if (e_err && e_cnt < ERR_MAX) e_cnt++;
      checks++; if (err_cnt !== ERR_W'(e_cnt)) begin failures++; $display("FAIL rnd_err_cnt i=%0d got=%0d exp=%0d", i, err_cnt, e_cnt); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    enter_run(5'd31, 4'd15, 1'b0);
    @(negedge sck);
    src0_valid = 1'b0; fifo_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge sck); #1;
      if (i == 199) begin
        checks++; if (err_cnt !== ERR_W'(200)) begin failures++; $display("FAIL sat_mid got=%0d exp=200", err_cnt); end
      end
    end
    checks++; if (err_cnt !== ERR_W'(ERR_MAX)) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", err_cnt, ERR_MAX); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL sat_err got=%b exp=1", err); end
  endtask

  task automatic test_disable_mid_frame();
    logic found = 1'b0;
    do_reset();
    enter_run(5'd15, 4'd1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (bit_idx == 5'd7) begin found = 1'b1; break; end
      @(posedge sck); #1;
    end
    checks++; if (!found) begin failures++; $display("FAIL dis_reach_bit7 got=%0d exp=7", bit_idx); end
    @(negedge sck);
    cfg_en = 1'b0; src0_valid = 1'b1; src0_data = $urandom; fifo_ready = 1'b1; #1;
    checks++; if (src0_ready !== 1'b1) begin failures++; $display("FAIL dis_inflight_ready got=%b exp=1", src0_ready); end
    @(posedge sck); #1;
    checks++; if (bit_idx !== 5'd0) begin failures++; $display("FAIL dis_bit got=%0d exp=0", bit_idx); end
    checks++; if (word_idx !== 4'd0) begin failures++; $display("FAIL dis_word got=%0d exp=0", word_idx); end
    checks++; if (frame_cnt !== '0) begin failures++; $display("FAIL dis_frame got=%0d exp=0", frame_cnt); end
    checks++; if (ws !== 1'b0) begin failures++; $display("FAIL dis_ws got=%b exp=0", ws); end
    checks++; if ({src0_ready, src1_ready, fifo_valid} !== 3'b000) begin failures++; $display("FAIL dis_readies got=%b exp=000", {src0_ready, src1_ready, fifo_valid}); end
    @(negedge sck);
    cfg_en = 1'b1; cfg_2ch = 1'b0; src1_valid = 1'b1;
    @(posedge sck);
    for (int i = 0; i < 6; i++) begin
      @(negedge sck);
      src0_data = $urandom; src1_data = $urandom; #1;
      checks++; if ({src0_ready, src1_ready} !== 2'b10) begin failures++; $display("FAIL reen_1ch_ready i=%0d got=%b exp=10", i, {src0_ready, src1_ready}); end
      checks++; if (fifo_data !== src0_data) begin failures++; $display("FAIL reen_1ch_data i=%0d got=%h exp=%h", i, fifo_data, src0_data); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enter_run(5'd1, 4'd1, 1'b0);
    repeat (4) @(posedge sck);
    #1;
    checks++; if (ws !== 1'b1) begin failures++; $display("FAIL arst_pre_ws got=%b exp=1", ws); end
    checks++; if (frame_cnt !== FRAME_W'(2)) begin failures++; $display("FAIL arst_pre_frame got=%0d exp=2", frame_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ws !== 1'b0) begin failures++; $display("FAIL arst_ws got=%b exp=0", ws); end
    checks++; if (frame_cnt !== '0) begin failures++; $display("FAIL arst_frame got=%0d exp=0", frame_cnt); end
    checks++; if ({bit_idx, word_idx} !== 9'd0) begin failures++; $display("FAIL arst_idx got=%0d/%0d exp=0/0", bit_idx, word_idx); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL arst_err_cnt got=%0d exp=0", err_cnt); end
    @(negedge sck);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_2ch_order();
    test_frame_timing(15, 1);
    test_frame_timing(0, 0);
    test_frame_timing($urandom_range(0, 31), $urandom_range(0, 3));
    test_frame_timing($urandom_range(0, 7), $urandom_range(0, 15));
    test_underrun();
    test_saturation();
    test_disable_mid_frame();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
